// File: rtl/gecko_fetch_align_pkg.sv
// Shared types for the fetch-to-decode alignment slice: fetch command,
// aligned instruction and the configuration tags passed to storage.
package gecko_fetch_align_pkg;

  typedef logic [7:0] std_clock_info_t;

  typedef enum logic [1:0] {
    STD_TECHNOLOGY_FPGA_XILINX,
    STD_TECHNOLOGY_FPGA_INTEL,
    STD_TECHNOLOGY_ASIC
  } std_technology_t;

  typedef logic [31:0] gecko_pc_t;
  typedef logic [2:0]  gecko_jump_flag_t;
  typedef logic [1:0]  gecko_prediction_t;
  typedef logic [31:0] riscv32_instruction_t;

  typedef struct packed {
    gecko_pc_t         pc;
    gecko_pc_t         next_pc;
    gecko_jump_flag_t  jump_flag;
    gecko_prediction_t prediction;
  } gecko_instruction_operation_t;

  typedef struct packed {
    gecko_pc_t            pc;
    gecko_pc_t            next_pc;
    gecko_jump_flag_t     jump_flag;
    gecko_prediction_t    prediction;
    riscv32_instruction_t instruction;
  } gecko_aligned_instruction_t;

  function automatic gecko_aligned_instruction_t gecko_align(
    input gecko_instruction_operation_t op,
    input riscv32_instruction_t         instruction
  );
    gecko_aligned_instruction_t result;
    result.pc          = op.pc;
    result.next_pc     = op.next_pc;
    result.jump_flag   = op.jump_flag;
    result.prediction  = op.prediction;
    result.instruction = instruction;
    return result;
  endfunction

endpackage

// File: rtl/gecko_fetch_align_if.sv
// Stream and memory-response interfaces. Handshake rule for both: a transfer
// happens on a rising clk edge where valid && ready; the source keeps payload
// stable while valid && !ready, and ready never depends on the source's valid.
interface stream_intf #(
  parameter type T = logic
);
  logic valid;
  logic ready;
  T     payload;

  modport out    (output valid, output payload, input ready);
  modport in     (input valid, input payload, output ready);
  modport master (output valid, output payload, input ready);
  modport slave  (input valid, input payload, output ready);
endinterface

interface mem_intf #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  valid;
  logic                  ready;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data;

  modport out    (output valid, output addr, output data, input ready);
  modport in     (input valid, input addr, input data, output ready);
  modport master (output valid, output addr, output data, input ready);
  modport slave  (input valid, input addr, input data, output ready);
endinterface

// File: rtl/gecko_fetch_align_stream_fifo.sv
// Generic first-word-fall-through FIFO; a write becomes visible at the head
// one cycle later, and push is ignored while full (no same-cycle bypass).
module stream_fifo
  import gecko_fetch_align_pkg::*;
#(
  parameter type             T          = logic [31:0],
  parameter int              DEPTH      = 4,
  parameter std_clock_info_t CLOCK_INFO = 'b0,
  parameter std_technology_t TECHNOLOGY = STD_TECHNOLOGY_FPGA_XILINX
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     push_data,
  output logic full,
  input  logic pop,
  output T     pop_data,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  T            storage [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        unused_config;

  // Storage is plain registers for every technology; the tags only travel along.
  assign unused_config = ^{CLOCK_INFO, TECHNOLOGY};

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_data = storage[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      storage[wr_ptr[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/gecko_fetch_align.sv
// Pairs fetch commands with in-order instruction words, drops pairs fetched
// under a stale jump flag and presents valid-only instructions to decode.
module gecko_fetch_align
  import gecko_fetch_align_pkg::*;
#(
  parameter std_clock_info_t CLOCK_INFO       = 'b0,
  parameter std_technology_t TECHNOLOGY       = STD_TECHNOLOGY_FPGA_XILINX,
  parameter int              DEPTH            = 4,
  parameter int              DROP_COUNT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  stream_intf.in                      instruction_command,
  mem_intf.in                         instruction_result,
  input  logic                        jump_flag_update_valid,
  input  gecko_jump_flag_t            jump_flag_update_value,
  stream_intf.out                     aligned_instruction,
  output logic [DROP_COUNT_WIDTH-1:0] drop_count
);

  localparam logic [DROP_COUNT_WIDTH-1:0] COUNT_ONE = 1;

  gecko_instruction_operation_t c_head;
  logic [31:0]                  r_head;
  logic                         c_full;
  logic                         c_empty;
  logic                         r_full;
  logic                         r_empty;
  logic                         c_push;
  logic                         r_push;
  logic                         pair_ready;
  logic                         head_stale;
  logic                         pair_pop;
  gecko_jump_flag_t             expected_flag;
  gecko_jump_flag_t             effective_flag;
  logic                         unused_addr;

  assign unused_addr = ^instruction_result.addr;

  assign instruction_command.ready = rst && !c_full;
  assign instruction_result.ready  = rst && !r_full;
  assign c_push = instruction_command.valid && instruction_command.ready;
  assign r_push = instruction_result.valid && instruction_result.ready;

  stream_fifo #(
    .T          (gecko_instruction_operation_t),
    .DEPTH      (DEPTH),
    .CLOCK_INFO (CLOCK_INFO),
    .TECHNOLOGY (TECHNOLOGY)
  ) command_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (c_push),
    .push_data (instruction_command.payload),
    .full      (c_full),
    .pop       (pair_pop),
    .pop_data  (c_head),
    .empty     (c_empty)
  );

  stream_fifo #(
    .T          (logic [31:0]),
    .DEPTH      (DEPTH),
    .CLOCK_INFO (CLOCK_INFO),
    .TECHNOLOGY (TECHNOLOGY)
  ) result_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (r_push),
    .push_data (instruction_result.data),
    .full      (r_full),
    .pop       (pair_pop),
    .pop_data  (r_head),
    .empty     (r_empty)
  );

  // A redirect committed this cycle already counts, so a stale head is never offered.
  assign effective_flag = jump_flag_update_valid ? jump_flag_update_value : expected_flag;

  assign pair_ready = rst && !c_empty && !r_empty;
  assign head_stale = pair_ready && (c_head.jump_flag != effective_flag);

  assign aligned_instruction.valid   = pair_ready && !head_stale;
  assign aligned_instruction.payload = gecko_align(c_head, r_head);

  // Both FIFOs always pop together so they stay in lock-step.
  assign pair_pop = head_stale || (aligned_instruction.valid && aligned_instruction.ready);

  always_ff @(posedge clk) begin
    if (!rst) begin
      expected_flag <= '0;
      drop_count    <= '0;
    end else begin
      expected_flag <= effective_flag;
      if (head_stale && (drop_count != '1)) begin
        drop_count <= drop_count + COUNT_ONE;
      end
    end
  end

  response_without_command: assert property (
    @(posedge clk) disable iff (!rst) !(c_empty && !r_empty)
  );

endmodule

// File: tb/tb_gecko_fetch_align.sv
// Directed bench for gecko_fetch_align: streaming, memory skew, redirect
// flush, same-cycle retraction, backpressure hold, mid-run reset and flag wrap.
module tb_gecko_fetch_align;
  import gecko_fetch_align_pkg::*;

  logic             clk;
  logic             rst;
  logic             upd_valid;
  gecko_jump_flag_t upd_value;
  logic [15:0]      drop_count;

  int n_checks = 0;
  int n_fail   = 0;
  int n_hs     = 0;

  logic [63:0] exp_q[$];

  stream_intf #(.T(gecko_instruction_operation_t)) cmd_if ();
  mem_intf #(.DATA_WIDTH(32), .ADDR_WIDTH(32))     res_if ();
  stream_intf #(.T(gecko_aligned_instruction_t))   out_if ();

  gecko_fetch_align #(
    .CLOCK_INFO       ('b0),
    .TECHNOLOGY       (STD_TECHNOLOGY_FPGA_XILINX),
    .DEPTH            (4),
    .DROP_COUNT_WIDTH (16)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .instruction_command    (cmd_if),
    .instruction_result     (res_if),
    .jump_flag_update_valid (upd_valid),
    .jump_flag_update_value (upd_value),
    .aligned_instruction    (out_if),
    .drop_count             (drop_count)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic drive_cmd(input logic v, input logic [31:0] pc, input gecko_jump_flag_t flag);
    cmd_if.valid   = v;
    cmd_if.payload = '{pc: pc, next_pc: pc + 32'd4, jump_flag: flag, prediction: 2'b01};
  endtask

  task automatic drive_res(input logic v, input logic [31:0] data);
    res_if.valid = v;
    res_if.data  = data;
  endtask

  task automatic drive_upd(input logic v, input gecko_jump_flag_t value);
    upd_valid = v;
    upd_value = value;
  endtask

  task automatic expect_issue(input logic [31:0] pc, input logic [31:0] instr);
    exp_q.push_back({pc, instr});
  endtask

  task automatic check_out(input string tag, input logic v, input logic [31:0] pc);
    check({tag, "_valid"}, 64'(out_if.valid), 64'(v));
    if (v) check({tag, "_pc"}, 64'(out_if.payload.pc), 64'(pc));
  endtask

  // scoreboard: every decode handshake must match the head of exp_q
  always @(negedge clk) begin
    if (rst && out_if.valid && out_if.ready) begin
      n_hs++;
      if (exp_q.size() == 0) begin
        check("unexpected_issue", {out_if.payload.pc, out_if.payload.instruction}, 64'hffff_ffff_ffff_ffff);
      end else begin
        check("issue_pc_instr", {out_if.payload.pc, out_if.payload.instruction}, exp_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b0;
    drive_cmd(1'b0, 32'h0, 3'd0);
    drive_res(1'b0, 32'h0);
    drive_upd(1'b0, 3'd0);
    res_if.addr  = 32'h0;
    out_if.ready = 1'b0;

    // reset
    next_cycle(); settle();
    next_cycle(); settle();
    check("rst_cmd_ready", 64'(cmd_if.ready), 64'h0);
    check("rst_res_ready", 64'(res_if.ready), 64'h0);
    check("rst_valid", 64'(out_if.valid), 64'h0);
    check("rst_drop_count", 64'(drop_count), 64'h0);
    next_cycle(); rst = 1'b1; settle();
    check("rel_cmd_ready", 64'(cmd_if.ready), 64'h1);
    check("rel_res_ready", 64'(res_if.ready), 64'h1);
    check("rel_valid", 64'(out_if.valid), 64'h0);

    // post-reset streaming
    expect_issue(32'h0, 32'h0000_0013);
    expect_issue(32'h4, 32'h0010_0093);
    expect_issue(32'h8, 32'h0020_0113);
    out_if.ready = 1'b1;
    next_cycle(); drive_cmd(1'b1, 32'h0, 3'd0); settle();
    check_out("t1_empty", 1'b0, 32'h0);
    next_cycle(); drive_cmd(1'b1, 32'h4, 3'd0); drive_res(1'b1, 32'h0000_0013); settle();
    check_out("t1_no_result", 1'b0, 32'h0);
    next_cycle(); drive_cmd(1'b1, 32'h8, 3'd0); drive_res(1'b1, 32'h0010_0093); settle();
    check_out("t1_first", 1'b1, 32'h0);
    next_cycle(); drive_cmd(1'b0, 32'h0, 3'd0); drive_res(1'b1, 32'h0020_0113); settle();
    check_out("t1_second", 1'b1, 32'h4);
    next_cycle(); drive_res(1'b0, 32'h0); settle();
    check_out("t1_third", 1'b1, 32'h8);
    next_cycle(); settle();
    check_out("t1_drained", 1'b0, 32'h0);
    check("t1_drop_count", 64'(drop_count), 64'h0);

    // memory skew: four commands, results three cycles later
    for (int i = 0; i < 5; i++) expect_issue(32'h10 + 32'(4 * i), 32'hA000_0000 + 32'(i));
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      drive_cmd(1'b1, 32'h10 + 32'(4 * i), 3'd0);
      if (i == 3) drive_res(1'b1, 32'hA000_0000);
      settle();
      check_out("t2_wait", 1'b0, 32'h0);
    end
    next_cycle(); drive_cmd(1'b1, 32'h20, 3'd0); drive_res(1'b1, 32'hA000_0001); settle();
    check("t2_full_stall", 64'(cmd_if.ready), 64'h0);
    check_out("t2_out0", 1'b1, 32'h10);
    next_cycle(); drive_res(1'b1, 32'hA000_0002); settle();
    check("t2_ready_again", 64'(cmd_if.ready), 64'h1);
    check_out("t2_out1", 1'b1, 32'h14);
    next_cycle(); drive_cmd(1'b0, 32'h0, 3'd0); drive_res(1'b1, 32'hA000_0003); settle();
    check_out("t2_out2", 1'b1, 32'h18);
    next_cycle(); drive_res(1'b1, 32'hA000_0004); settle();
    check_out("t2_out3", 1'b1, 32'h1c);
    next_cycle(); drive_res(1'b0, 32'h0); settle();
    check_out("t2_out4", 1'b1, 32'h20);
    next_cycle(); settle();
    check_out("t2_drained", 1'b0, 32'h0);

    // redirect flush of three buffered flag-0 pairs
    out_if.ready = 1'b0;
    next_cycle(); drive_cmd(1'b1, 32'h40, 3'd0); settle();
    next_cycle(); drive_cmd(1'b1, 32'h44, 3'd0); drive_res(1'b1, 32'hD000_0000); settle();
    next_cycle(); drive_cmd(1'b1, 32'h48, 3'd0); drive_res(1'b1, 32'hD000_0001); settle();
    next_cycle(); drive_cmd(1'b0, 32'h0, 3'd0); drive_res(1'b1, 32'hD000_0002); settle();
    check_out("t3_head_held", 1'b1, 32'h40);
    next_cycle(); drive_res(1'b0, 32'h0); drive_upd(1'b1, 3'd1); settle();
    check_out("t3_drop0", 1'b0, 32'h0);
    next_cycle(); drive_upd(1'b0, 3'd0); settle();
    check_out("t3_drop1", 1'b0, 32'h0);
    check("t3_count1", 64'(drop_count), 64'h1);
    next_cycle(); settle();
    check("t3_count2", 64'(drop_count), 64'h2);
    expect_issue(32'h100, 32'h0050_0293);
    next_cycle(); drive_cmd(1'b1, 32'h100, 3'd1); settle();
    check_out("t3_flushed", 1'b0, 32'h0);
    check("t3_count3", 64'(drop_count), 64'h3);
    next_cycle(); drive_cmd(1'b0, 32'h0, 3'd0); drive_res(1'b1, 32'h0050_0293); out_if.ready = 1'b1; settle();
    next_cycle(); drive_res(1'b0, 32'h0); settle();
    check_out("t3_new_flag", 1'b1, 32'h100);
    check("t3_new_flag_jf", 64'(out_if.payload.jump_flag), 64'h1);
    next_cycle(); settle();

    // same-cycle update retracts a held head
    out_if.ready = 1'b0;
    next_cycle(); drive_cmd(1'b1, 32'h200, 3'd1); settle();
    next_cycle(); drive_cmd(1'b0, 32'h0, 3'd0); drive_res(1'b1, 32'hBEEF_0001); settle();
    next_cycle(); drive_res(1'b0, 32'h0); settle();
    check_out("t4_offered", 1'b1, 32'h200);
    next_cycle(); drive_upd(1'b1, 3'd2); out_if.ready = 1'b1; settle();
    check_out("t4_retract", 1'b0, 32'h0);
    next_cycle(); drive_upd(1'b0, 3'd0); settle();
    check_out("t4_gone", 1'b0, 32'h0);
    check("t4_count", 64'(drop_count), 64'h4);

    // backpressure hold
    expect_issue(32'h300, 32'hAAAA_0001);
    expect_issue(32'h304, 32'hAAAA_0002);
    out_if.ready = 1'b0;
    next_cycle(); drive_cmd(1'b1, 32'h300, 3'd2); settle();
    next_cycle(); drive_cmd(1'b1, 32'h304, 3'd2); drive_res(1'b1, 32'hAAAA_0001); settle();
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      drive_cmd(1'b0, 32'h0, 3'd0);
      drive_res(i == 0, 32'hAAAA_0002);
      settle();
      check("t5_hold", {out_if.payload.pc, out_if.payload.instruction}, {32'h300, 32'hAAAA_0001});
      check("t5_hold_valid", 64'(out_if.valid), 64'h1);
    end
    next_cycle(); drive_res(1'b0, 32'h0); out_if.ready = 1'b1; settle();
    check_out("t5_release", 1'b1, 32'h300);
    next_cycle(); out_if.ready = 1'b0; settle();
    check_out("t5_single", 1'b1, 32'h304);
    next_cycle(); out_if.ready = 1'b1; settle();
    next_cycle(); settle();
    check_out("t5_drained", 1'b0, 32'h0);

    // reset mid-run with two pairs buffered
    out_if.ready = 1'b0;
    next_cycle(); drive_cmd(1'b1, 32'h400, 3'd2); settle();
    next_cycle(); drive_cmd(1'b1, 32'h404, 3'd2); drive_res(1'b1, 32'hCC00_0000); settle();
    next_cycle(); drive_cmd(1'b0, 32'h0, 3'd0); drive_res(1'b1, 32'hCC00_0001); settle();
    next_cycle(); drive_res(1'b0, 32'h0); settle();
    check_out("t6_buffered", 1'b1, 32'h400);
    next_cycle(); rst = 1'b0; settle();
    check_out("t6_in_reset", 1'b0, 32'h0);
    check("t6_rst_cmd_ready", 64'(cmd_if.ready), 64'h0);
    next_cycle(); rst = 1'b1; out_if.ready = 1'b1; settle();
    check_out("t6_flushed", 1'b0, 32'h0);
    check("t6_drop_count", 64'(drop_count), 64'h0);
    check("t6_cmd_ready", 64'(cmd_if.ready), 64'h1);

    // flag-0 accepted after reset, then wrap 7 -> 0
    expect_issue(32'h500, 32'h0000_0011);
    expect_issue(32'h600, 32'h0000_0022);
    expect_issue(32'h608, 32'h0000_0044);
    next_cycle(); drive_cmd(1'b1, 32'h500, 3'd0); settle();
    next_cycle(); drive_cmd(1'b0, 32'h0, 3'd0); drive_res(1'b1, 32'h0000_0011); settle();
    next_cycle(); drive_res(1'b0, 32'h0); settle();
    check_out("t6_flag0", 1'b1, 32'h500);
    next_cycle(); drive_upd(1'b1, 3'd7); settle();
    next_cycle(); drive_upd(1'b0, 3'd0); drive_cmd(1'b1, 32'h600, 3'd7); settle();
    next_cycle(); drive_cmd(1'b0, 32'h0, 3'd0); drive_res(1'b1, 32'h0000_0022); settle();
    next_cycle(); drive_res(1'b0, 32'h0); settle();
    check_out("t6_flag7", 1'b1, 32'h600);
    next_cycle(); drive_upd(1'b1, 3'd0); settle();
    next_cycle(); drive_upd(1'b0, 3'd0); drive_cmd(1'b1, 32'h604, 3'd7); settle();
    next_cycle(); drive_cmd(1'b1, 32'h608, 3'd0); drive_res(1'b1, 32'h0000_0033); settle();
    next_cycle(); drive_cmd(1'b0, 32'h0, 3'd0); drive_res(1'b1, 32'h0000_0044); settle();
    check_out("t6_wrap_stale", 1'b0, 32'h0);
    next_cycle(); drive_res(1'b0, 32'h0); settle();
    check_out("t6_wrap_issue", 1'b1, 32'h608);
    check("t6_wrap_drops", 64'(drop_count), 64'h1);
    next_cycle(); settle();
    check_out("t6_drained", 1'b0, 32'h0);

    // final report
    check("handshake_count", 64'(n_hs), 64'd14);
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
